sign_class_arbiter: RTL

Round-robin arbiter that shares one registered sign-classification stage among NREQ requesters. Each requester presents a signed two's-complement sample with a valid/ready handshake. The arbiter grants one requester per cycle, classifies the granted sample as positive, negative or zero, and delivers the result with the requester ID through a single-entry output register with valid/ready. It sits between the sample producers and any downstream consumer of the positive/negative flags, replacing per-producer classifier instances.

---
 rtl/sign_class_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/sign_class_arbiter.sv
// sign_class_arbiter: round-robin share of one registered sign classifier among NREQ requesters.
// Latency: 1 cycle from an accepted sample to out_valid carrying its id and pos/neg/zero flags.
// Backpressure: single-entry output register; req_ready is all zero while a result waits on out_ready.
module sign_class_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(NREQ)-1:0] out_id,
  output logic                    out_pos,
  output logic                    out_neg,
  output logic                    out_zero
);

  localparam int             IDW     = $clog2(NREQ);
  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  // Search origin for the next grant; moves only when a sample is actually taken.
  logic [IDW-1:0] rr_ptr;

  logic           can_load;
  logic           load_ok;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   cand;
  logic [DW-1:0]  sel_data;
  logic           xfer;
  logic           nxt_neg;
  logic           nxt_zero;
  logic           nxt_pos;

  // The register frees up in the same cycle its result is consumed; reset blocks all grants.
  assign can_load = !out_valid || out_ready;
  assign load_ok  = can_load && !rst;
  assign xfer     = load_ok && grant_found;

  // Walk upward from rr_ptr, wrapping modulo NREQ; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // One-hot ready to the winner, only when the output register can take a result.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = xfer && (grant_idx == IDW'(i));
    end
  end

  // Select the winning sample; it is only registered, never passed straight to an output.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Sign classification: the MSB alone marks negative, so the most negative value is negative.
  always_comb begin
    nxt_neg  = sel_data[DW-1];
    nxt_zero = (sel_data == '0);
    nxt_pos  = !sel_data[DW-1] && (sel_data != '0);
  end

  // Output register and pointer: load on transfer, clear valid on a drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_pos   <= 1'b0;
      out_neg   <= 1'b0;
      out_zero  <= 1'b0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_id    <= grant_idx;
      out_pos   <= nxt_pos;
      out_neg   <= nxt_neg;
      out_zero  <= nxt_zero;
      rr_ptr    <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
